// File: rtl/servo_pkg.sv
// ============================================================================
// Module   : servo_pkg
// Desc     : Shared widths, default frame/pulse constants and FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package servo_pkg;

  localparam int unsigned CYCLE_W           = 25;
  localparam int unsigned DEF_PERIOD_CYCLES = 1_000_000;
  localparam int unsigned DEF_MIN_CYCLES    = 25_000;
  localparam int unsigned DEF_MAX_CYCLES    = 125_000;
  localparam int unsigned DEF_STEP_MAX      = 500;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : servo_pkg

`default_nettype wire

// File: rtl/servo_slew_limit.sv
// ============================================================================
// Module   : servo_slew_limit
// Desc     : Combinational clamp of a raw target followed by a per-frame step limit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module servo_slew_limit
  import servo_pkg::*;
#(
  parameter int unsigned MIN_CYCLES = DEF_MIN_CYCLES,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int unsigned STEP_MAX   = DEF_STEP_MAX
) (
  input  logic [CYCLE_W-1:0] cur_width_i,
  input  logic [CYCLE_W-1:0] target_i,
  output logic [CYCLE_W-1:0] next_width_o
);

  localparam logic [CYCLE_W-1:0] c_min = CYCLE_W'(MIN_CYCLES);
  localparam logic [CYCLE_W-1:0] c_max = CYCLE_W'(MAX_CYCLES);

  logic [CYCLE_W-1:0] w_clamp;

  always_comb begin
    w_clamp = target_i;
    if (target_i < c_min) begin
      w_clamp = c_min;
    end else if (target_i > c_max) begin
      w_clamp = c_max;
    end
  end

  generate
    if (STEP_MAX == 0) begin : g_no_slew
      assign next_width_o = w_clamp;
    end else begin : g_slew
      localparam logic [CYCLE_W-1:0] c_step = CYCLE_W'(STEP_MAX);

      // Direction is decided first so each subtraction is non-negative.
      always_comb begin
        next_width_o = w_clamp;
        if (w_clamp >= cur_width_i) begin
          if ((w_clamp - cur_width_i) > c_step) begin
            next_width_o = cur_width_i + c_step;
          end
        end else begin
          if ((cur_width_i - w_clamp) > c_step) begin
            next_width_o = cur_width_i - c_step;
          end
        end
      end
    end
  endgenerate

endmodule : servo_slew_limit

`default_nettype wire

// File: rtl/servo_pwm_gen.sv
// ============================================================================
// Module   : servo_pwm_gen
// Desc     : Fixed-frame servo PWM; target is sampled, clamped and slewed per frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned MIN_CYCLES    = DEF_MIN_CYCLES,
  parameter int unsigned MAX_CYCLES    = DEF_MAX_CYCLES,
  parameter int unsigned STEP_MAX      = DEF_STEP_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [CYCLE_W-1:0] cycles_target,
  output logic               pwm_out,
  output logic               frame_start,
  output logic [CYCLE_W-1:0] active_width,
  output logic               running
);

  localparam logic [CYCLE_W-1:0] c_period_last = CYCLE_W'(PERIOD_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] c_min         = CYCLE_W'(MIN_CYCLES);

  state_e             state_q;
  logic [CYCLE_W-1:0] k_q;
  logic [CYCLE_W-1:0] width_q;
  logic [CYCLE_W-1:0] width_d;
  logic [CYCLE_W-1:0] w_k_inc;
  logic               pwm_q;
  logic               frame_start_q;
  logic               running_q;

  servo_slew_limit #(
    .MIN_CYCLES (MIN_CYCLES),
    .MAX_CYCLES (MAX_CYCLES),
    .STEP_MAX   (STEP_MAX)
  ) u_slew (
    .cur_width_i  (width_q),
    .target_i     (cycles_target),
    .next_width_o (width_d)
  );

  assign w_k_inc = k_q + CYCLE_W'(1);

  // Outputs are registered against the counter value being entered, so
  // pwm_out/frame_start/running line up with k in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      k_q           <= '0;
      width_q       <= c_min;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          k_q <= '0;
          if (enable) begin
            state_q       <= RUN;
            width_q       <= width_d;
            pwm_q         <= (width_d != '0);
            frame_start_q <= 1'b1;
            running_q     <= 1'b1;
          end else begin
            pwm_q     <= 1'b0;
            running_q <= 1'b0;
          end
        end
        RUN: begin
          if (k_q == c_period_last) begin
            k_q <= '0;
            if (enable) begin
              width_q       <= width_d;
              pwm_q         <= (width_d != '0);
              frame_start_q <= 1'b1;
            end else begin
              state_q   <= IDLE;
              pwm_q     <= 1'b0;
              running_q <= 1'b0;
            end
          end else begin
            k_q   <= w_k_inc;
            pwm_q <= (w_k_inc < width_q);
          end
        end
        default: begin
          state_q   <= IDLE;
          k_q       <= '0;
          pwm_q     <= 1'b0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_out      = pwm_q;
  assign frame_start  = frame_start_q;
  assign active_width = width_q;
  assign running      = running_q;

endmodule : servo_pwm_gen

`default_nettype wire
